// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: operation codes, MIPS opcode/funct values and field positions.
// Used by the decode stage and the ALU.
package alu_defs;

    localparam int          REG_IDX_W  = 5;
    localparam int          RF_DEPTH   = 32;

    localparam logic [4:0]  OP_ADD      = 5'd0;
    localparam logic [4:0]  OP_SUB      = 5'd1;
    localparam logic [4:0]  OP_AND      = 5'd2;
    localparam logic [4:0]  OP_OR       = 5'd3;
    localparam logic [4:0]  OP_XOR      = 5'd4;
    localparam logic [4:0]  OP_NOR      = 5'd5;
    localparam logic [4:0]  OP_SLL      = 5'd6;
    localparam logic [4:0]  OP_SRL      = 5'd7;
    localparam logic [4:0]  OP_SLT      = 5'd8;
    localparam logic [4:0]  OP_ADDI     = 5'd9;
    localparam logic [4:0]  OP_ANDI     = 5'd10;
    localparam logic [4:0]  OP_ORI      = 5'd11;
    localparam logic [4:0]  ALU_ILLEGAL = 5'h1F;

    localparam logic [5:0]  OPC_RTYPE  = 6'h00;
    localparam logic [5:0]  OPC_ADDI   = 6'h08;
    localparam logic [5:0]  OPC_ANDI   = 6'h0C;
    localparam logic [5:0]  OPC_ORI    = 6'h0D;

    localparam logic [5:0]  FN_ADD     = 6'h20;
    localparam logic [5:0]  FN_SUB     = 6'h22;
    localparam logic [5:0]  FN_AND     = 6'h24;
    localparam logic [5:0]  FN_OR      = 6'h25;
    localparam logic [5:0]  FN_XOR     = 6'h26;
    localparam logic [5:0]  FN_NOR     = 6'h27;
    localparam logic [5:0]  FN_SLL     = 6'h00;
    localparam logic [5:0]  FN_SRL     = 6'h02;
    localparam logic [5:0]  FN_SLT     = 6'h2A;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       illegal;
        logic       rtype;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t d;
        d.alu_op  = ALU_ILLEGAL;
        d.illegal = 1'b0;
        d.rtype   = (instr[OPC_MSB:OPC_LSB] == OPC_RTYPE);
        case (instr[OPC_MSB:OPC_LSB])
            OPC_RTYPE: begin
                case (instr[FN_MSB:FN_LSB])
                    FN_ADD:  d.alu_op = OP_ADD;
                    FN_SUB:  d.alu_op = OP_SUB;
                    FN_AND:  d.alu_op = OP_AND;
                    FN_OR:   d.alu_op = OP_OR;
                    FN_XOR:  d.alu_op = OP_XOR;
                    FN_NOR:  d.alu_op = OP_NOR;
                    FN_SLL:  d.alu_op = OP_SLL;
                    FN_SRL:  d.alu_op = OP_SRL;
                    FN_SLT:  d.alu_op = OP_SLT;
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_ADDI: d.alu_op = OP_ADDI;
            OPC_ANDI: d.alu_op = OP_ANDI;
            OPC_ORI:  d.alu_op = OP_ORI;
            default:  d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: one write port, two combinational read ports with
// write-through bypass; R0 always reads zero.
module regfile_32x32
    import alu_defs::*;
#(
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [31:0]          i_wdata,
    input  logic [REG_IDX_W-1:0] i_raddr_a,
    input  logic [REG_IDX_W-1:0] i_raddr_b,
    output logic [31:0]          o_rdata_a,
    output logic [31:0]          o_rdata_b
);

    logic [31:0] r_mem [NREGS];

    // Storage update; R0 is never written so its entry stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port A with same-cycle write-through.
    always_comb begin
        if (i_raddr_a == 5'd0) begin
            o_rdata_a = 32'd0;
        end else if (i_we && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end else begin
            o_rdata_a = r_mem[i_raddr_a];
        end
    end

    // Read port B with same-cycle write-through.
    always_comb begin
        if (i_raddr_b == 5'd0) begin
            o_rdata_b = 32'd0;
        end else if (i_we && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end else begin
            o_rdata_b = r_mem[i_raddr_b];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode / operand fetch stage feeding the ALU. Decoded operands sit
// in a one-entry output register under a valid/ready handshake.
module decode_stage
    import alu_defs::*;
#(
    parameter int         NREGS      = 32,
    parameter logic [4:0] ILLEGAL_OP = 5'h1F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [15:0] imm,
    output logic [4:0]  sh,
    output logic [4:0]  ALUop,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic        w_accept;
    logic        w_xfer;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    dec_t        w_dec;
    logic [4:0]  w_alu_op;
    logic [4:0]  w_rd;

    logic        r_valid;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [15:0] r_imm;
    logic [4:0]  r_sh;
    logic [4:0]  r_alu_op;
    logic [4:0]  r_rd;
    logic        r_illegal;

    regfile_32x32 #(.NREGS(NREGS)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (instr[RS_MSB:RS_LSB]),
        .i_raddr_b (instr[RT_MSB:RT_LSB]),
        .o_rdata_a (w_rs_val),
        .o_rdata_b (w_rt_val)
    );

    assign instr_ready = !rst && (!r_valid || out_ready);
    assign w_accept    = instr_valid && instr_ready;
    assign w_xfer      = r_valid && out_ready;

    assign w_dec    = decode_instr(instr);
    assign w_alu_op = w_dec.illegal ? ILLEGAL_OP : w_dec.alu_op;
    // I-type (and undecodable non-R-type) instructions name their target in rt.
    assign w_rd     = w_dec.rtype ? instr[RD_MSB:RD_LSB] : instr[RT_MSB:RT_LSB];

    // Output register: load on accept, drain on transfer, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_in1     <= 32'd0;
            r_in2     <= 32'd0;
            r_imm     <= 16'd0;
            r_sh      <= 5'd0;
            r_alu_op  <= 5'd0;
            r_rd      <= 5'd0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_in1     <= w_rs_val;
            r_in2     <= w_rt_val;
            r_imm     <= instr[IMM_MSB:IMM_LSB];
            r_sh      <= instr[SH_MSB:SH_LSB];
            r_alu_op  <= w_alu_op;
            r_rd      <= w_rd;
            r_illegal <= w_dec.illegal;
        end else if (w_xfer) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign in1       = r_in1;
    assign in2       = r_in2;
    assign imm       = r_imm;
    assign sh        = r_sh;
    assign ALUop     = r_alu_op;
    assign rd        = r_rd;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic [4:0]  ALUop;
    logic [4:0]  rd;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_in1, m_in2;
    logic [15:0] m_imm;
    logic [4:0]  m_sh, m_op, m_rd;
    logic        m_ill;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .in1(in1), .in2(in2), .imm(imm),
        .sh(sh), .ALUop(ALUop), .rd(rd), .illegal(illegal)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] d, input logic [4:0] s,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, d, s, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {opc, rs, rt, im};
    endfunction

    // Reference decode: the position of the funct in the table is the ALU code.
    function automatic logic [5:0] ref_decode(input logic [31:0] ins);
        logic [5:0] fn_tab [9];
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h2A};
        if (ins[31:26] == 6'h00) begin
            for (int i = 0; i < 9; i++)
                if (ins[5:0] == fn_tab[i]) return {1'b0, 5'(i)};
            return {1'b1, 5'h1F};
        end
        if (ins[31:26] == 6'h08) return {1'b0, 5'd9};
        if (ins[31:26] == 6'h0C) return {1'b0, 5'd10};
        if (ins[31:26] == 6'h0D) return {1'b0, 5'd11};
        return {1'b1, 5'h1F};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic [96:0] dut_vec();
        return {out_valid, in1, in2, imm, sh, ALUop, rd, illegal};
    endfunction

    function automatic logic [96:0] model_vec();
        return {m_valid, m_in1, m_in2, m_imm, m_sh, m_op, m_rd, m_ill};
    endfunction

    // Advance one clock edge and apply the same edge to the model; returns at edge+1.
    task automatic tick();
        logic       acc;
        logic [5:0] dec;
        acc = !rst && instr_valid && (!m_valid || out_ready);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            {m_valid, m_in1, m_in2, m_imm, m_sh, m_op, m_rd, m_ill} = '0;
        end else begin
            if (acc) begin
                dec     = ref_decode(instr);
                m_valid = 1'b1;
                m_in1   = ref_read(instr[25:21]);
                m_in2   = ref_read(instr[20:16]);
                m_imm   = instr[15:0];
                m_sh    = instr[10:6];
                m_op    = dec[4:0];
                m_ill   = dec[5];
                m_rd    = (instr[31:26] == 6'h00) ? instr[15:11] : instr[20:16];
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        end
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        wb_en       = 1'b0;
        out_ready   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b1; instr = 32'h00A01820;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0009; out_ready = 1'b1;
        tick(); tick();
        n_tests++;
        if (instr_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b exp 0", instr_ready);
        end
        n_tests++;
        if (dut_vec() !== 97'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h exp 0", dut_vec());
        end
        rst = 1'b0; instr_valid = 1'b0; wb_data = 32'd7;
        tick();
        wb_en = 1'b0; instr_valid = 1'b1; instr = 32'h00A01820;
        tick();
        instr_valid = 1'b0;
        n_tests++;
        if ({out_valid, in1, in2, ALUop, rd} !== {1'b1, 32'd7, 32'd0, 5'd0, 5'd3}) begin
            n_fail++;
            $display("FAIL add_after_reset: got v=%b in1=%h in2=%h op=%h rd=%h exp v=1 in1=7 in2=0 op=0 rd=3",
                     out_valid, in1, in2, ALUop, rd);
        end
        n_tests++;
        if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL add_after_reset_model: got %h exp %h", dut_vec(), model_vec());
        end
        tick();
    endtask

    task automatic test_decode_sweep();
        logic [5:0] fn_tab [9];
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h2A};
        idle_inputs();
        for (int r = 1; r < 8; r++) begin
            wb_en = 1'b1; wb_addr = 5'(r); wb_data = $urandom;
            tick();
        end
        wb_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            instr_valid = 1'b1;
            instr = rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom), 5'($urandom), fn_tab[i]);
            tick();
            n_tests++;
            if (ALUop !== 5'(i) || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL decode_funct_%0d: got op=%h vec=%h exp op=%h vec=%h",
                         i, ALUop, dut_vec(), 5'(i), model_vec());
            end
        end
        instr = rtype(5'd1, 5'd2, 5'd3, 5'd4, 6'h00);
        tick();
        n_tests++;
        if (sh !== 5'd4 || ALUop !== 5'd6) begin
            n_fail++; $display("FAIL sll_shamt: got sh=%h op=%h exp sh=4 op=6", sh, ALUop);
        end
        instr = itype(6'h0D, 5'd1, 5'd2, 16'hBEEF);
        tick();
        n_tests++;
        if ({ALUop, imm, rd, in2, illegal} !== {5'd11, 16'hBEEF, 5'd2, m_regs[2], 1'b0}) begin
            n_fail++;
            $display("FAIL ori: got op=%h imm=%h rd=%h in2=%h ill=%b exp op=b imm=beef rd=2 in2=%h ill=0",
                     ALUop, imm, rd, in2, illegal, m_regs[2]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int k;
        logic [31:0] tab [5];
        for (int c = 0; c < 200; c++) begin
            k = $urandom_range(0, 3);
            tab[0] = rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'h20 + 6'($urandom_range(0, 7)));
            tab[1] = rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
            tab[2] = itype((k == 2) ? 6'h08 : 6'h0C, 5'($urandom), 5'($urandom), 16'($urandom));
            tab[3] = $urandom;
            instr_valid = 1'($urandom);
            instr       = tab[k];
            out_ready   = ($urandom_range(0, 3) != 0);
            wb_en       = 1'($urandom);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            #1;
            n_tests++;
            if (instr_ready !== (!m_valid || out_ready)) begin
                n_fail++; $display("FAIL rand_ready_%0d: got %b exp %b", c, instr_ready, !m_valid || out_ready);
            end
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rand_vec_%0d: got %h exp %h", c, dut_vec(), model_vec());
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_bypass();
        idle_inputs();
        instr_valid = 1'b1; instr = 32'h00A50822;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        n_tests++;
        if ({in1, in2, ALUop, rd} !== {32'hDEADBEEF, 32'hDEADBEEF, 5'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL bypass: got in1=%h in2=%h op=%h rd=%h exp deadbeef deadbeef 1 1", in1, in2, ALUop, rd);
        end
        instr = rtype(5'd0, 5'd5, 5'd3, 5'd0, 6'h20);
        wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        n_tests++;
        if ({in1, in2} !== {32'd0, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL r0_write_cycle: got in1=%h in2=%h exp 0 deadbeef", in1, in2);
        end
        wb_en = 1'b0; instr = rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h25);
        tick();
        n_tests++;
        if ({in1, in2} !== 64'd0) begin
            n_fail++; $display("FAIL r0_read: got in1=%h in2=%h exp 0 0", in1, in2);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        logic [96:0] snap;
        logic [31:0] a_ins, b_ins;
        idle_inputs();
        a_ins = rtype(5'd5, 5'd6, 5'd7, 5'd1, 6'h24);
        b_ins = rtype(5'd5, 5'd2, 5'd9, 5'd2, 6'h26);
        instr_valid = 1'b1; instr = a_ins; out_ready = 1'b0;
        tick();
        snap = dut_vec();
        instr = b_ins;
        for (int c = 0; c < 3; c++) begin
            wb_en = 1'b1; wb_addr = 5'd5; wb_data = $urandom;
            tick();
            n_tests++;
            if (instr_ready !== 1'b0 || dut_vec() !== snap || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got rdy=%b vec=%h exp rdy=0 vec=%h", c, instr_ready, dut_vec(), snap);
            end
        end
        wb_en = 1'b0; out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || ALUop !== 5'd4 || rd !== 5'd9 || in1 !== m_regs[5]
            || dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL back_to_back: got %h exp %h", dut_vec(), model_vec());
        end
        instr_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain: got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        idle_inputs();
        instr_valid = 1'b1; instr = {6'h3F, 26'($urandom)};
        tick();
        instr_valid = 1'b0;
        n_tests++;
        if ({out_valid, ALUop, illegal} !== {1'b1, 5'h1F, 1'b1} || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL illegal: got v=%b op=%h ill=%b exp v=1 op=1f ill=1", out_valid, ALUop, illegal);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL illegal_xfer: got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0055;
        tick();
        wb_en = 1'b0; instr_valid = 1'b1; instr = rtype(5'd5, 5'd0, 5'd1, 5'd0, 6'h20);
        out_ready = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || in1 !== 32'h55) begin
            n_fail++; $display("FAIL pre_reset_load: got v=%b in1=%h exp v=1 in1=55", out_valid, in1);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (dut_vec() !== 97'd0) begin
            n_fail++; $display("FAIL mid_reset: got %h exp 0", dut_vec());
        end
        rst = 1'b0; out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || in1 !== 32'd0) begin
            n_fail++; $display("FAIL r5_after_reset: got v=%b in1=%h exp v=1 in1=0", out_valid, in1);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        {m_valid, m_in1, m_in2, m_imm, m_sh, m_op, m_rd, m_ill} = '0;
        rst = 1'b1; instr = 32'd0; wb_addr = 5'd0; wb_data = 32'd0;
        idle_inputs();
        test_reset();
        test_decode_sweep();
        test_bypass();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode / operand-fetch stage directly upstream of the ALU; produces in1, in2, imm, sh and ALUop for it.
- Accepts one 32-bit MIPS-format instruction per handshake and reads rs/rt from an internal 32x32 register file.
- Register file is written by a writeback port, with same-cycle write-through bypass.
- Holds decoded operands in a one-entry output register under a valid/ready handshake.

Parameters:
- NREGS, 32, register file depth (index width 5, fixed).
- ILLEGAL_OP, 5'h1F, ALUop value emitted for undecodable instructions.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  upstream instruction valid
- instr  in  32  instruction word
- instr_ready  out  1  stage can accept instr this cycle
- wb_en  in  1  register file write enable
- wb_addr  in  5  write index
- wb_data  in  32  write data
- out_valid  out  1  decoded operands valid toward ALU
- out_ready  in  1  ALU side accepts operands
- in1  out  32  operand A (R[rs])
- in2  out  32  operand B (R[rt])
- imm  out  16  instr[15:0]
- sh  out  5  instr[10:6]
- ALUop  out  5  ALU operation code
- rd  out  5  destination index (instr[15:11] R-type, instr[20:16] I-type)
- illegal  out  1  instruction not decodable

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0; in1, in2, imm, sh, ALUop, rd, illegal = 0.
  - All register file entries = 0.
  - An instruction presented in the same cycle is dropped.
  - A wb write in the same cycle is discarded.
- instr_ready = !out_valid || out_ready (combinational; 0 during rst).
- Accept = instr_valid && instr_ready.
  - On accept, the output register loads at the next edge and out_valid=1. Latency is 1 cycle.
- Output transfer = out_valid && out_ready.
  - Transfer with no accept: out_valid -> 0.
  - Transfer with accept in the same cycle: new value loaded, out_valid stays 1 (full throughput).
- Stall: while out_valid && !out_ready, all outputs hold bit-stable.
  - Writebacks during a stall do not refresh held in1/in2; hazards are owned by the hazard unit.
- Fields: opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- R-type (opcode 0), funct -> ALUop:
  - 0x20 ADD=0, 0x22 SUB=1, 0x24 AND=2, 0x25 OR=3, 0x26 XOR=4, 0x27 NOR=5, 0x00 SLL=6, 0x02 SRL=7, 0x2A SLT=8.
- I-type, opcode -> ALUop:
  - 0x08 ADDI=9, 0x0C ANDI=10, 0x0D ORI=11.
  - in2 still carries R[rt].
  - rd output = rt.
- Any other opcode/funct: ALUop=ILLEGAL_OP, illegal=1; the instruction is still accepted and passed downstream.
- imm and sh are always the raw fields, whatever the instruction format.
- Register file:
  - Write at clk edge when wb_en && wb_addr!=0.
  - Writes to R0 are ignored; reads of R0 always return 0.
- Bypass: in the accept cycle, if wb_en && wb_addr==rs && rs!=0, in1 loads wb_data rather than the stale entry. in2/rt is handled the same way.
- Simultaneous accept and writeback to the same index: the register file and the captured operand both take wb_data.

Decomposition:
- Shared package alu_defs:
  - ALUop constants 0..11 and ILLEGAL_OP.
  - opcode/funct constants.
  - Field-position constants.
  - Used by this block and the ALU.
- Sub-module regfile_32x32:
  - Synchronous reset, 1 write port, 2 combinational read ports with write-through bypass.
  - R0 hardwired to zero.

Test Plan:
- Reset: hold rst 2 cycles, then write R5=7 via wb.
  - Next, add r3,r5,r0 (0x00A01820) -> in1=7, in2=0, ALUop=0, rd=3, out_valid=1 one cycle after accept.
- Decode sweep: R-type functs 0x20,0x22,0x24,0x25,0x26,0x27,0x00,0x02,0x2A -> ALUop 0..8.
  - sll with shamt=4 -> sh=4.
  - ori r2,r1,0xBEEF -> ALUop=11, imm=0xBEEF, rd=2.
- Bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF in the same cycle sub r1,r5,r5 is accepted -> in1=in2=0xDEADBEEF.
  - A write to R0 with 0xFFFF_FFFF -> later reads of R0 return 0.
- Backpressure: out_ready=0 for 3 cycles with a second instr pending.
  - instr_ready=0, outputs unchanged.
  - Raise out_ready -> back-to-back transfers, no loss or duplication.
- Illegal: opcode 0x3F -> ALUop=0x1F, illegal=1, handshake completes normally.
- Reset mid-operation: rst while out_valid=1 and stalled -> out_valid=0 next edge, R5 reads 0 afterwards.
